i2s_audio_tx: RTL



---
 rtl/i2s_audio_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: stereo I2S slave transmitter; frames enter a small FIFO and are
// serialised MSB-first on i2s_dout, aligned to the codec-driven SCLK/LRCLK.
`timescale 1ns/1ps
module i2s_audio_tx #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          i2s_sclk,
  input  logic                          i2s_lrclk,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic [DATA_W-1:0]             sample_left,
  input  logic [DATA_W-1:0]             sample_right,
  output logic                          i2s_dout,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SLOT_W);

  logic [2:0] sclk_q, sclk_d;
  logic [1:0] lr_q, lr_d;
  logic lr_prev_q, lr_prev_d, ch_q, ch_d, start_q, start_d, armed_q, armed_d;
  logic dout_q, dout_d, underrun_q, underrun_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] left_sh_q, left_sh_d, right_sh_q, right_sh_d, cur, cur_sh;
  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [2*DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic sfall, trans, load, push, pop;

  always_comb begin
    sclk_d = {sclk_q[1:0], i2s_sclk};
    lr_d = {lr_q[0], i2s_lrclk};
    sfall = sclk_q[2] & ~sclk_q[1];
    trans = sfall & (lr_q[1] ^ lr_prev_q);
    load = trans & ~lr_q[1];
    sample_ready = lvl_q != LW'(FIFO_DEPTH);
    push = sample_valid & sample_ready;
    pop = load & (lvl_q != '0);
    cur = ch_q ? right_sh_q : left_sh_q;
    cur_sh = cur << 1;
    cnt_inc = (cnt_q == CW'(SLOT_W - 1)) ? cnt_q : cnt_q + CW'(1);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {sample_left, sample_right};
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    lvl_d = lvl_q + LW'(push) - LW'(pop);
    lr_prev_d = lr_prev_q;
    ch_d = ch_q;
    start_d = start_q;
    armed_d = armed_q;
    cnt_d = cnt_q;
    dout_d = dout_q;
    underrun_d = 1'b0;
    left_sh_d = left_sh_q;
    right_sh_d = right_sh_q;
    if (sfall) begin
      lr_prev_d = lr_q[1];
      // first sfall after an LRCLK edge drives the MSB; the edge itself still finishes the old slot
      if (start_q && !trans) begin
        cnt_d = '0;
        start_d = 1'b0;
        dout_d = armed_q & cur[DATA_W-1];
      end else begin
        cnt_d = cnt_inc;
        dout_d = armed_q && (32'(cnt_inc) < DATA_W) && cur_sh[DATA_W-1];
        if (ch_q) right_sh_d = cur_sh;
        else left_sh_d = cur_sh;
      end
      if (trans) begin
        ch_d = lr_q[1];
        start_d = 1'b1;
      end
      if (load) begin
        armed_d = 1'b1;
        underrun_d = ~pop;
        {left_sh_d, right_sh_d} = pop ? mem_q[rd_q] : '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sclk_q <= '0;
      lr_q <= '0;
      lr_prev_q <= 1'b0;
      ch_q <= 1'b0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q <= '0;
      dout_q <= 1'b0;
      underrun_q <= 1'b0;
      left_sh_q <= '0;
      right_sh_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sclk_q <= sclk_d;
      lr_q <= lr_d;
      lr_prev_q <= lr_prev_d;
      ch_q <= ch_d;
      start_q <= start_d;
      armed_q <= armed_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      underrun_q <= underrun_d;
      left_sh_q <= left_sh_d;
      right_sh_q <= right_sh_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      mem_q <= mem_d;
    end
  end

  assign i2s_dout = dout_q;
  assign underrun = underrun_q;
  assign fifo_level = lvl_q;
endmodule
